run_control: RTL and testbench

Debug run-control sequencer for the single-cycle RISC-V core. Gates the core's clock enable so an external debug host can halt, resume, single/multi-step and set hardware breakpoints. Observes the core's `debug_pc` and `debug_instruction` and stops execution *before* a breakpoint or `ebreak` instruction commits. Sits between the debug command interface and the `main` core's commit enable.

---
 rtl/debug_pkg.sv | 31 +++
 rtl/bp_match.sv | 32 +++
 rtl/run_control.sv | 141 ++++++++++++++
 tb/tb_run_control.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared encodings for the debug run-control block: command ops, halt causes,
// sequencer states and the ebreak opcode.
package debug_pkg;

  typedef enum logic [1:0] {
    OP_HALT   = 2'b00,
    OP_RUN    = 2'b01,
    OP_STEP   = 2'b10,
    OP_SET_BP = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    CAUSE_HALT   = 2'b00,
    CAUSE_BP     = 2'b01,
    CAUSE_STEP   = 2'b10,
    CAUSE_EBREAK = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_STEPPING = 2'b10
  } state_e;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  function automatic logic is_ebreak(input logic [31:0] instr);
    return instr == EBREAK;
  endfunction

endpackage

// File: rtl/bp_match.sv
// One hardware breakpoint: a word address plus enable, compared against the
// word address of the current PC.
module bp_match #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [XLEN-1:2] wr_addr,
  input  logic            wr_en,
  input  logic [XLEN-1:2] pc_word,
  output logic            hit
);

  logic [XLEN-1:2] addr;
  logic            en;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
      en   <= 1'b0;
    end else if (wr) begin
      addr <= wr_addr;
      en   <= wr_en;
    end
  end

  assign hit = en & (pc_word == addr);

endmodule

// File: rtl/run_control.sv
// Debug run-control sequencer: gates the core's commit enable to implement
// halt, run, counted stepping and two hardware breakpoints plus ebreak.
module run_control
  import debug_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STEP_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [XLEN-1:0] cmd_arg,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr,
  output logic            core_en,
  output logic            halted,
  output logic [1:0]      halt_cause,
  output logic [31:0]     retired_cnt
);

  state_e              state, state_nxt;
  cause_e              cause, cause_nxt;
  logic [STEP_W-1:0]   step_cnt, step_nxt;
  logic                skip, skip_nxt;

  op_e                 op;
  logic                halt_req;
  logic                set_bp;
  logic [1:0]          bp_hit;
  logic                instr_is_ebreak;
  logic                stop;
  logic [STEP_W-1:0]   step_arg;
  logic                unused_pc_bits;

  assign op              = op_e'(cmd_op);
  assign halt_req        = cmd_valid & (op == OP_HALT);
  assign set_bp          = cmd_valid & cmd_ready & (op == OP_SET_BP);
  assign step_arg        = cmd_arg[STEP_W-1:0];
  assign instr_is_ebreak = is_ebreak(instr);
  assign unused_pc_bits  = ^pc[1:0];

  // skip masks the check for the first instruction after a resume so the
  // instruction that caused the halt is allowed to commit.
  assign stop = ~skip & ((|bp_hit) | instr_is_ebreak);

  for (genvar i = 0; i < 2; i++) begin : g_bp
    bp_match #(
      .XLEN(XLEN)
    ) u_bp (
      .clk    (clk),
      .reset  (reset),
      .wr     (set_bp & (cmd_arg[1] == 1'(i))),
      .wr_addr(cmd_arg[XLEN-1:2]),
      .wr_en  (cmd_arg[0]),
      .pc_word(pc[XLEN-1:2]),
      .hit    (bp_hit[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_HALTED;
      cause    <= CAUSE_HALT;
      step_cnt <= '0;
      skip     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cause    <= cause_nxt;
      step_cnt <= step_nxt;
      skip     <= skip_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    step_nxt  = step_cnt;
    skip_nxt  = skip;
    unique case (state)
      ST_HALTED: begin
        if (cmd_valid) begin
          unique case (op)
            OP_HALT: cause_nxt = CAUSE_HALT;
            OP_RUN: begin
              state_nxt = ST_RUNNING;
              skip_nxt  = 1'b1;
            end
            OP_STEP: begin
              if (step_arg == '0) begin
                cause_nxt = CAUSE_STEP;
              end else begin
                step_nxt  = step_arg;
                state_nxt = ST_STEPPING;
                skip_nxt  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_RUNNING, ST_STEPPING: begin
        if (halt_req) begin
          state_nxt = ST_HALTED;
          cause_nxt = CAUSE_HALT;
        end else if (stop) begin
          state_nxt = ST_HALTED;
          cause_nxt = instr_is_ebreak ? CAUSE_EBREAK : CAUSE_BP;
        end else begin
          // Commit edge: the core retires the instruction at pc.
          skip_nxt = 1'b0;
          if (state == ST_STEPPING) begin
            step_nxt = step_cnt - STEP_W'(1);
            if (step_cnt == STEP_W'(1)) begin
              state_nxt = ST_HALTED;
              cause_nxt = CAUSE_STEP;
            end
          end
        end
      end
      default: state_nxt = ST_HALTED;
    endcase
  end

  always_comb begin
    halted    = (state == ST_HALTED);
    core_en   = ~halted & ~stop & ~halt_req;
    cmd_ready = halted | (op == OP_HALT) | (op == OP_SET_BP);
  end

  always_ff @(posedge clk) begin
    if (reset)        retired_cnt <= '0;
    else if (core_en) retired_cnt <= retired_cnt + 32'd1;
  end

  assign halt_cause = cause;

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control: a fake core advances pc on every commit and
// a scoreboard queue holds expected values until the DUT is observed.
module tb_run_control;
  import debug_pkg::*;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] NO_EBREAK = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        core_en;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] retired_cnt;
  logic [31:0] ebreak_pc;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   pulses    = 0;

  always #5 clk = ~clk;

  assign instr = (pc == ebreak_pc) ? EBREAK : NOP_INSTR;

  run_control dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .pc         (pc),
    .instr      (instr),
    .core_en    (core_en),
    .halted     (halted),
    .halt_cause (halt_cause),
    .retired_cnt(retired_cnt)
  );

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] act);
    exp_t e;
    n_asserts++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: got %0h required a queued expectation", act);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (act === e.exp) else begin
        n_fail++;
        $error("FAIL %s: got %0h required %0h", e.tag, act, e.exp);
      end
    end
  endtask

  // One clock: commit decision sampled mid-cycle, fake core advances pc after the edge.
  task automatic step_clk();
    logic en;
    en = core_en;
    @(posedge clk);
    #1;
    if (en === 1'b1) begin
      pc = pc + 32'd4;
      pulses++;
    end
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    #1;
    step_clk();
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic wait_halt(input int bound);
    for (int i = 0; i < bound && halted !== 1'b1; i++) step_clk();
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_arg   = '0;
    pc        = '0;
    ebreak_pc = NO_EBREAK;
    step_clk();
    step_clk();
    reset = 1'b0;
    pc    = '0;
    #1;

    // Reset state
    expect_val("rst_halted", 32'd1);       observe(32'(halted));
    expect_val("rst_cause", 32'd0);        observe(32'(halt_cause));
    expect_val("rst_core_en", 32'd0);      observe(32'(core_en));
    expect_val("rst_retired", 32'd0);      observe(retired_cnt);
    expect_val("rst_ready", 32'd1);        observe(32'(cmd_ready));

    // RUN: commits from the next cycle, one per cycle
    expect_val("run_core_en", 32'd1);
    expect_val("run_halted", 32'd0);
    send_cmd(OP_RUN, '0);
    observe(32'(core_en));
    observe(32'(halted));
    expect_val("run_retired3", 32'd3);
    for (int i = 0; i < 3; i++) step_clk();
    observe(retired_cnt);

    // HALT while running: commit blocked in the accepting cycle
    cmd_valid = 1'b1;
    cmd_op    = OP_HALT;
    #1;
    expect_val("halt_same_cycle_en", 32'd0); observe(32'(core_en));
    expect_val("halt_ready", 32'd1);         observe(32'(cmd_ready));
    step_clk();
    cmd_valid = 1'b0;
    #1;
    expect_val("halt_halted", 32'd1);   observe(32'(halted));
    expect_val("halt_cause", 32'd0);    observe(32'(halt_cause));
    expect_val("halt_retired", 32'd3);  observe(retired_cnt);

    // Breakpoint 0 at 0x10, run into it from 0xC
    send_cmd(OP_SET_BP, 32'h0000_0011);
    send_cmd(OP_RUN, '0);
    step_clk();
    expect_val("bp_pc", 32'h10);        observe(pc);
    expect_val("bp_core_en", 32'd0);    observe(32'(core_en));
    step_clk();
    expect_val("bp_halted", 32'd1);     observe(32'(halted));
    expect_val("bp_cause", 32'd1);      observe(32'(halt_cause));
    expect_val("bp_retired", 32'd4);    observe(retired_cnt);

    // Resume over the breakpoint; RUN while running is back-pressured
    send_cmd(OP_RUN, '0);
    expect_val("resume_core_en", 32'd1); observe(32'(core_en));
    step_clk();
    cmd_valid = 1'b1;
    cmd_op    = OP_RUN;
    #1;
    expect_val("run_busy_ready", 32'd0);  observe(32'(cmd_ready));
    expect_val("run_busy_core_en", 32'd1); observe(32'(core_en));
    step_clk();
    cmd_valid = 1'b0;
    #1;
    send_cmd(OP_HALT, '0);
    expect_val("resume_retired", 32'd6);  observe(retired_cnt);
    expect_val("resume_pc", 32'h18);      observe(pc);

    // STEP 3 (upper arg bits must be ignored)
    pulses = 0;
    send_cmd(OP_STEP, 32'h0001_0003);
    wait_halt(10);
    expect_val("step3_pulses", 32'd3);    observe(32'(pulses));
    expect_val("step3_halted", 32'd1);    observe(32'(halted));
    expect_val("step3_cause", 32'd2);     observe(32'(halt_cause));
    expect_val("step3_retired", 32'd9);   observe(retired_cnt);

    // STEP 0 after truncation: stays halted, cause step-done, no commits
    send_cmd(OP_HALT, '0);
    expect_val("pre_step0_cause", 32'd0); observe(32'(halt_cause));
    pulses = 0;
    send_cmd(OP_STEP, 32'h0001_0000);
    for (int i = 0; i < 3; i++) step_clk();
    expect_val("step0_halted", 32'd1);    observe(32'(halted));
    expect_val("step0_cause", 32'd2);     observe(32'(halt_cause));
    expect_val("step0_pulses", 32'd0);    observe(32'(pulses));
    expect_val("step0_retired", 32'd9);   observe(retired_cnt);

    // Ebreak at 0x2C with breakpoint 1 on the same address: ebreak wins
    ebreak_pc = 32'h2C;
    send_cmd(OP_SET_BP, 32'h0000_002F);
    pulses = 0;
    send_cmd(OP_RUN, '0);
    wait_halt(10);
    expect_val("ebreak_pulses", 32'd2);   observe(32'(pulses));
    expect_val("ebreak_cause", 32'd3);    observe(32'(halt_cause));
    expect_val("ebreak_pc", 32'h2C);      observe(pc);
    expect_val("ebreak_retired", 32'd11); observe(retired_cnt);

    // Reset in the middle of a STEP 5
    send_cmd(OP_STEP, 32'd5);
    step_clk();
    step_clk();
    expect_val("midstep_halted", 32'd0);  observe(32'(halted));
    expect_val("midstep_retired", 32'd13); observe(retired_cnt);
    reset = 1'b1;
    #1;
    step_clk();
    reset = 1'b0;
    #1;
    expect_val("rst2_halted", 32'd1);     observe(32'(halted));
    expect_val("rst2_cause", 32'd0);      observe(32'(halt_cause));
    expect_val("rst2_retired", 32'd0);    observe(retired_cnt);
    expect_val("rst2_core_en", 32'd0);    observe(32'(core_en));

    // Breakpoints were cleared: 0x10 no longer stops the core
    ebreak_pc = NO_EBREAK;
    pc        = 32'h0C;
    send_cmd(OP_RUN, '0);
    step_clk();
    expect_val("bp_cleared_pc", 32'h10);  observe(pc);
    expect_val("bp_cleared_en", 32'd1);   observe(32'(core_en));
    send_cmd(OP_HALT, '0);
    expect_val("final_halted", 32'd1);    observe(32'(halted));
    expect_val("final_retired", 32'd1);   observe(retired_cnt);

    expect_val("scoreboard_drained", 32'd0);
    observe(32'(sb.size() - 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
